// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit positions and mode/direction types for the
// multi-channel PWM block.
package pwm_pkg;

    localparam int unsigned ADDR_CTRL = 0;
    localparam int unsigned ADDR_TOP  = 1;
    localparam int unsigned ADDR_CNT  = 2;
    localparam int unsigned ADDR_CMP0 = 3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_BIT = 1;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: sawtooth or triangle counting, force-load, restart,
// period boundary detection and the registered period_end pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             restart,
    input  logic             load,
    input  logic             run,
    input  pwm_mode_e        mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] top_act,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary,
    output logic             period_end
);

    pwm_dir_e         dir, dir_nxt;
    logic [WIDTH-1:0] cnt_nxt;

    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (restart) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (load) begin
            cnt_nxt = load_val;
            if (mode == PWM_CENTER && load_val > top_act) dir_nxt = DIR_DOWN;
        end else if (run) begin
            if (mode == PWM_EDGE) begin
                if (cnt < top_act) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end
            end else if (dir == DIR_UP) begin
                if (cnt < top_act) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (cnt == '0) begin
                    boundary = 1'b1;            // top_act == 0: parked at zero
                end else begin
                    dir_nxt = DIR_DOWN;
                    cnt_nxt = cnt - 1'b1;
                end
            end else begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    dir_nxt  = DIR_UP;
                    cnt_nxt  = (top_act == '0) ? '0 : WIDTH'(1);
                    boundary = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            period_end <= boundary;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: register decode, double-buffered TOP/CMP registers and
// per-channel compare outputs around a shared timebase.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    cnt,
    output logic [WIDTH-1:0]    top,
    output logic                period_end,
    output logic [CHANNELS-1:0] out
);

    logic             en;
    pwm_mode_e        mode;
    logic [WIDTH-1:0] top_sh, top_act;

    logic      ctrl_wr, new_en, en_rise, restart, run, load, boundary, transfer;
    pwm_mode_e new_mode;

    assign ctrl_wr  = wr_en && (wr_addr == AW'(ADDR_CTRL));
    assign new_en   = wr_data[CTRL_EN_BIT];
    assign new_mode = pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
    assign en_rise  = ctrl_wr && new_en && !en;
    assign restart  = en_rise || (ctrl_wr && new_mode != mode);
    // A CTRL write that clears en freezes the counter at that same edge.
    assign run      = en && !(ctrl_wr && !new_en);
    assign load     = wr_en && (wr_addr == AW'(ADDR_CNT));
    assign transfer = en_rise || boundary;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en      <= 1'b0;
            mode    <= PWM_EDGE;
            top_sh  <= '0;
            top_act <= '0;
        end else begin
            if (ctrl_wr) begin
                en   <= new_en;
                mode <= new_mode;
            end
            if (wr_en && wr_addr == AW'(ADDR_TOP)) top_sh <= wr_data;
            if (transfer) top_act <= top_sh;
        end
    end

    pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
        .clk        (clk),
        .nrst       (nrst),
        .restart    (restart),
        .load       (load),
        .run        (run),
        .mode       (mode),
        .load_val   (wr_data),
        .top_act    (top_act),
        .cnt        (cnt),
        .boundary   (boundary),
        .period_end (period_end)
    );

    assign top = top_act;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [AW-1:0] CMP_ADDR = AW'(ADDR_CMP0 + i);
        logic [WIDTH-1:0] cmp_sh, cmp_act;

        // NOTE: the per-channel register arrays are plain flops, so they take the async reset like any other state.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                cmp_sh  <= '0;
                cmp_act <= '0;
            end else begin
                if (wr_en && wr_addr == CMP_ADDR) cmp_sh <= wr_data;
                if (transfer) cmp_act <= cmp_sh;
            end
        end

        assign out[i] = en && (cnt < cmp_act);
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: a fixed vector table, directed corner
// sequences, and random register traffic against a behavioural model.
module tb_pwm_multi;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int AW = 5;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          nrst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  cnt, top;
    logic          period_end;
    logic [CH-1:0] out_v;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .AW(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cnt        (cnt),
        .top        (top),
        .period_end (period_end),
        .out        (out_v)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_en, m_mode, m_down, m_pe;
    int m_cnt, m_top_sh, m_top_act;
    int m_cmp_sh[CH];
    int m_cmp_act[CH];

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_down = 0; m_pe = 0;
        m_cnt = 0; m_top_sh = 0; m_top_act = 0;
        for (int i = 0; i < CH; i++) begin
            m_cmp_sh[i] = 0;
            m_cmp_act[i] = 0;
        end
    endtask

    task automatic model_step(input bit we, input int a, input int d);
        bit ctrl, d_en, d_mode, bnd, xfer, nd;
        int nxt, step;
        ctrl   = we && (a == 0);
        d_en   = d[0];
        d_mode = d[1];
        bnd = 0; xfer = 0; nxt = m_cnt; nd = m_down;
        if (ctrl && d_en && !m_en) begin
            nxt = 0; nd = 0; xfer = 1;
        end else if (ctrl && d_mode != m_mode) begin
            nxt = 0; nd = 0;
        end else if (we && a == 2) begin
            nxt = d;
            if (m_mode && d > m_top_act) nd = 1;
        end else if (m_en && !(ctrl && !d_en)) begin
            if (!m_mode) begin
                // sawtooth: position modulo (top+1), anything above top wraps
                nxt = (m_cnt > m_top_act) ? 0 : (m_cnt + 1) % (m_top_act + 1);
                bnd = (nxt == 0);
            end else begin
                // triangle: step one way, reflect at top and below zero
                step = m_down ? -1 : 1;
                nxt  = m_cnt + step;
                if (nxt > m_top_act) begin
                    if (m_cnt == 0) begin nxt = 0; bnd = 1; end
                    else begin nd = 1; nxt = m_cnt - 1; end
                end else if (nxt < 0) begin
                    nd = 0; bnd = 1;
                    nxt = (m_top_act == 0) ? 0 : 1;
                end
            end
        end
        if (xfer || bnd) begin
            m_top_act = m_top_sh;
            for (int i = 0; i < CH; i++) m_cmp_act[i] = m_cmp_sh[i];
        end
        if (we && a == 1) m_top_sh = d;
        for (int i = 0; i < CH; i++) if (we && a == 3 + i) m_cmp_sh[i] = d;
        if (ctrl) begin m_en = d_en; m_mode = d_mode; end
        m_cnt = nxt; m_down = nd; m_pe = bnd;
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0] eo;
        for (int i = 0; i < CH; i++) eo[i] = m_en && (m_cnt < m_cmp_act[i]);
        check({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
        check({tag, ".top"}, 32'(top), 32'(m_top_act));
        check({tag, ".pe"},  32'(period_end), 32'(m_pe));
        check({tag, ".out"}, 32'(out_v), 32'(eo));
    endtask

    // Drive one clock of bus activity; the model advances in lockstep.
    task automatic apply(input bit we, input int a, input int d);
        wr_en   = we;
        wr_addr = AW'(a);
        wr_data = W'(d);
        model_step(we, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit we, input int a, input int d);
        apply(we, a, d);
        check_all("model");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        int            addr;
        int            data;
        logic [W-1:0]  cnt;
        logic [W-1:0]  top;
        logic          pe;
        logic [CH-1:0] out;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int frozen;
        int k;
        // edge mode TOP=4 CMP0=2, then switch to centre mode
        vecs[0]  = '{1'b1, 1, 4, 16'd0, 16'd0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 3, 2, 16'd0, 16'd0, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 0, 1, 16'd0, 16'd4, 1'b0, 4'b0001};
        vecs[3]  = '{1'b0, 0, 0, 16'd1, 16'd4, 1'b0, 4'b0001};
        vecs[4]  = '{1'b0, 0, 0, 16'd2, 16'd4, 1'b0, 4'b0000};
        vecs[5]  = '{1'b0, 0, 0, 16'd3, 16'd4, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 0, 0, 16'd4, 16'd4, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 0, 0, 16'd0, 16'd4, 1'b1, 4'b0001};
        vecs[8]  = '{1'b0, 0, 0, 16'd1, 16'd4, 1'b0, 4'b0001};
        vecs[9]  = '{1'b1, 0, 3, 16'd0, 16'd4, 1'b0, 4'b0001};
        vecs[10] = '{1'b0, 0, 0, 16'd1, 16'd4, 1'b0, 4'b0001};
        vecs[11] = '{1'b0, 0, 0, 16'd2, 16'd4, 1'b0, 4'b0000};
        vecs[12] = '{1'b0, 0, 0, 16'd3, 16'd4, 1'b0, 4'b0000};
        vecs[13] = '{1'b0, 0, 0, 16'd4, 16'd4, 1'b0, 4'b0000};
        vecs[14] = '{1'b0, 0, 0, 16'd3, 16'd4, 1'b0, 4'b0000};
        vecs[15] = '{1'b0, 0, 0, 16'd2, 16'd4, 1'b0, 4'b0000};
        vecs[16] = '{1'b0, 0, 0, 16'd1, 16'd4, 1'b0, 4'b0001};
        vecs[17] = '{1'b0, 0, 0, 16'd0, 16'd4, 1'b0, 4'b0001};
        vecs[18] = '{1'b0, 0, 0, 16'd1, 16'd4, 1'b1, 4'b0001};
        vecs[19] = '{1'b0, 0, 0, 16'd2, 16'd4, 1'b0, 4'b0000};

        nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #12;
        check("reset.cnt", 32'(cnt), 32'd0);
        check("reset.top", 32'(top), 32'd0);
        check("reset.pe",  32'(period_end), 32'd0);
        check("reset.out", 32'(out_v), 32'd0);
        nrst = 1'b1;

        for (int v = 0; v < NV; v++) begin
            apply(vecs[v].we, vecs[v].addr, vecs[v].data);
            check($sformatf("vec%0d.cnt", v), 32'(cnt), 32'(vecs[v].cnt));
            check($sformatf("vec%0d.top", v), 32'(top), 32'(vecs[v].top));
            check($sformatf("vec%0d.pe", v),  32'(period_end), 32'(vecs[v].pe));
            check($sformatf("vec%0d.out", v), 32'(out_v), 32'(vecs[v].out));
        end

        // shadow update mid-period: old TOP/CMP finish the period
        step(1, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 9);
        check("upd.top_old", 32'(top), 32'd4);
        step(1, 4, 5);
        check("upd.out1_old", 32'(out_v[1]), 32'd0);
        step(0, 0, 0);
        check("upd.top_new", 32'(top), 32'd9);
        check("upd.out_new", 32'(out_v), 32'b0011);
        check("upd.pe", 32'(period_end), 32'd1);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // force-load above top in edge and centre modes
        step(1, 1, 4);
        k = 0;
        while (m_top_act != 4 && k < 40) begin step(0, 0, 0); k++; end
        check("ld.top_ready", 32'(top), 32'd4);
        step(1, 2, 7);
        check("ld.edge_cnt", 32'(cnt), 32'd7);
        check("ld.edge_pe",  32'(period_end), 32'd0);
        step(0, 0, 0);
        check("ld.edge_wrap", 32'(cnt), 32'd0);
        check("ld.edge_pe2",  32'(period_end), 32'd1);
        step(1, 0, 3);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 2, 7);
        step(0, 0, 0);
        check("ld.ctr_6", 32'(cnt), 32'd6);
        step(0, 0, 0);
        check("ld.ctr_5", 32'(cnt), 32'd5);
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // compare extremes, then disable
        step(1, 0, 1);
        step(1, 3, 0);
        step(1, 4, 'hFFFF);
        step(1, 1, 3);
        k = 0;
        while (m_top_act != 3 && k < 40) begin step(0, 0, 0); k++; end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            check("cmp.out10", 32'(out_v[1:0]), 32'b10);
        end
        step(1, 0, 0);
        check("off.out", 32'(out_v), 32'd0);
        frozen = m_cnt;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            check("off.cnt", 32'(cnt), 32'(frozen));
        end

        // asynchronous reset mid-period
        step(1, 0, 1);
        k = 0;
        while (m_cnt != 3 && k < 20) begin step(0, 0, 0); k++; end
        check("rst.pre_cnt", 32'(cnt), 32'd3);
        #2 nrst = 1'b0;
        #1;
        check("rst.cnt", 32'(cnt), 32'd0);
        check("rst.top", 32'(top), 32'd0);
        check("rst.out", 32'(out_v), 32'd0);
        check("rst.pe",  32'(period_end), 32'd0);
        model_reset();
        #2 nrst = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check("rst.hold", 32'(cnt), 32'd0);
        step(1, 0, 1);

        // random register traffic
        for (int i = 0; i < 800; i++) begin
            int a, d;
            if ($urandom_range(0, 5) != 0) begin
                step(0, 0, 0);
            end else begin
                a = int'($urandom_range(0, 3 + CH));
                if ($urandom_range(0, 9) == 0) a = int'($urandom_range(3 + CH, 31));
                case (a)
                    0:       d = ($urandom_range(0, 3) != 0 ? 1 : 0) | (int'($urandom_range(0, 1)) << 1);
                    1:       d = int'($urandom_range(0, 12));
                    2:       d = int'($urandom_range(0, 16));
                    default: d = ($urandom_range(0, 7) == 0) ? 'hFFFF : int'($urandom_range(0, 14));
                endcase
                step(1, a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator with one shared period counter and CHANNELS independent compare outputs.
- Edge-aligned (sawtooth) and centre-aligned (up/down) modes.
- TOP and CMP writes are double-buffered: shadow registers copy into active registers only at a period boundary, so no output glitch occurs when duty changes.
- Sits behind a simple register-write bus.
- Generalises the single-channel sel/d-programmed PWM with width, channel count, mode and glitch-free update.

Parameters:
- WIDTH, 16, counter/compare/top width.
- CHANNELS, 4, number of PWM outputs (1..16).
- AW, 5, write address width; must satisfy 2^AW >= 3+CHANNELS.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous active-low reset.
- wr_en  in  1  register write strobe, sampled on clk.
- wr_addr  in  AW  register address.
- wr_data  in  WIDTH  write data.
- cnt  out  WIDTH  current counter value.
- top  out  WIDTH  active period limit.
- period_end  out  1  one-cycle pulse, registered.
- out  out  CHANNELS  PWM outputs.

Behaviour:
- Register map:
  - 0 = CTRL: bit0 en, bit1 mode (0 edge, 1 centre).
  - 1 = TOP shadow.
  - 2 = CNT force-load.
  - 3+i = CMP shadow of channel i.
  - Writes to other addresses are ignored.
- Reset (nrst low, async): cnt, top, all shadow/active regs, en, mode, period_end = 0; direction = up; out = 0.
- Outputs:
  - out[i] = en & (cnt < cmp_act[i]), combinational from registers, no extra latency.
  - en=0 forces out=0.
- en=0: cnt holds its value; no shadow transfer occurs.
- Enable rising (CTRL write with en 0->1):
  - cnt <= 0, dir <= up.
  - top_act/cmp_act <= shadows at the same edge.
  - period_end stays low.
- CTRL write that changes mode: cnt <= 0, dir <= up. Shadows are not transferred unless en also rises.
- Edge mode, en=1:
  - cnt < top_act: cnt <= cnt+1.
  - Otherwise: cnt <= 0 (wrap, boundary).
  - Period = top_act+1 cycles.
- Centre mode, en=1:
  - dir up and cnt < top_act: cnt <= cnt+1. At cnt >= top_act: dir <= down, cnt <= cnt-1.
  - dir down and cnt > 0: cnt <= cnt-1. At cnt == 0: dir <= up, cnt <= 1 (boundary).
  - Period = 2*top_act cycles.
  - top_act=0: cnt stays 0 and every cycle is a boundary.
- Boundary cycle:
  - top_act <= top_sh and cmp_act[i] <= cmp_sh[i].
  - The next cycle has period_end=1.
- Simultaneous shadow write and boundary: the active register takes the pre-write shadow; the new value applies at the following boundary.
- CNT force-load:
  - Has priority over counting and is honoured even when en=0.
  - It is not a boundary: no transfer, no period_end.
  - Loaded value > top_act in edge mode: next enabled cycle wraps to 0 (boundary).
  - Loaded value > top_act in centre mode: dir <= down.
- Edge cases:
  - cmp_act > top_act: output constantly 1 while enabled.
  - cmp_act = 0: output constantly 0.
  - All arithmetic is modulo 2^WIDTH; the counter never exceeds max(top_act, force-loaded value).
- Reset mid-operation returns everything to reset values immediately; counting restarts only after a CTRL en write.

Decomposition:
- Package pwm_pkg:
  - Address constants ADDR_CTRL=0, ADDR_TOP=1, ADDR_CNT=2, ADDR_CMP0=3.
  - Enum pwm_mode_e {PWM_EDGE, PWM_CENTER}.
  - CTRL bit index constants.
- Sub-module pwm_timebase: counter, direction, mode logic, boundary and period_end generation.
- Top level holds: write decode, shadow/active register arrays (generate loop over CHANNELS), output compares.

Test Plan:
- Edge mode, TOP=4, CMP0=2, en=1 -> cnt 0,1,2,3,4,0...; out[0] high on cnt 0,1 (2/5 duty); period_end high each cycle cnt returns to 0.
- Centre mode, TOP=4, CMP0=2 -> cnt 0,1,2,3,4,3,2,1,0,1...; out[0] high on cnt 0,1; period 8 cycles; period_end after each valley.
- Edge, TOP=4 running, write TOP=9 and CMP1=5 while cnt=2 -> counts 3,4,0 with old values, then 0..9 with out[1] high for cnt 0..4.
- Write CNT=7 with top_act=4, edge mode -> next cycle cnt=0 and period_end follows; in centre mode cnt goes 6,5,... instead.
- CMP0=0 and CMP1=0xFFFF with TOP=3 -> out[0] always 0, out[1] always 1; en=0 -> all out=0 and cnt frozen.
- Assert nrst mid-period (cnt=3) -> cnt, top, out, period_end = 0 immediately; no counting until en is rewritten.
